// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: op codes, default widths,
// FSM state encoding and the legal-op check.
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_reg_bank.sv
// Register bank: DEPTH x DATA_W storage, two registered read ports, one write
// port shared between writeback and direct load (writeback wins).
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_a_q, rd_b_q;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign we    = wb_en_i | ld_en_i;
  assign waddr = wb_en_i ? wb_addr_i : ld_addr_i;
  assign wdata = wb_en_i ? wb_data_i : ld_data_i;

  // Storage is deliberately not reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else if (rd_en_i) begin
      rd_a_q <= mem_q[rd_addr_a_i];
      rd_b_q <= mem_q[rd_addr_b_i];
    end
  end

  assign rd_data_a_o = rd_a_q;
  assign rd_data_b_o = rd_b_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer beside the 32-bit ALU: accepts one instruction at a time,
// fetches operands from the bank, drives X/Y/S, captures r/Zflag, writes back.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [3:0]        inst_op,
  input  logic [ADDR_W-1:0] inst_ra,
  input  logic [ADDR_W-1:0] inst_rb,
  input  logic [ADDR_W-1:0] inst_rd,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [3:0]        alu_s,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zflag,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              zflag
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, alu_s_q;
  logic [ADDR_W-1:0] ra_q, rb_q, rd_q;
  logic [DATA_W-1:0] result_q;
  logic              zflag_q, done_q, err_q;
  logic              done_d, err_d, latch_en, capture_en, read_en, wb_en, ld_ok;

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    read_en    = 1'b0;
    wb_en      = 1'b0;
    ld_ok      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          if (is_legal_op(inst_op)) begin
            latch_en = 1'b1;
            state_d  = S_READ;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          ld_ok = ld_en;
        end
      end
      S_READ: begin
        read_en = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        capture_en = 1'b1;
        done_d     = 1'b1;
        state_d    = S_WB;
      end
      S_WB: begin
        wb_en   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      alu_s_q  <= '0;
      result_q <= '0;
      zflag_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (latch_en) begin
        op_q <= inst_op;
        ra_q <= inst_ra;
        rb_q <= inst_rb;
        rd_q <= inst_rd;
      end
      // S loads on the same edge as the operand read so X/Y/S change together.
      if (read_en) alu_s_q <= op_q;
      if (capture_en) begin
        result_q <= alu_r;
        zflag_q  <= alu_zflag;
      end
    end
  end

  reg_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (read_en),
    .rd_addr_a_i(ra_q),
    .rd_addr_b_i(rb_q),
    .rd_data_a_o(alu_x),
    .rd_data_b_o(alu_y),
    .wb_en_i    (wb_en),
    .wb_addr_i  (rd_q),
    .wb_data_i  (result_q),
    .ld_en_i    (ld_ok),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data)
  );

  assign inst_ready = (state_q == S_IDLE) && !rst;
  assign alu_s      = alu_s_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result     = result_q;
  assign zflag      = zflag_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized self-checking bench: behavioural ALU beside the sequencer and an
// array model of the register bank predicting every result and handshake.
module tb_alu_operand_sequencer;

  logic        clk, rst;
  logic        inst_valid, inst_ready;
  logic [3:0]  inst_op;
  logic [4:0]  inst_ra, inst_rb, inst_rd;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_x, alu_y, alu_r, result;
  logic [3:0]  alu_s;
  logic        alu_zflag, done, err, zflag;

  int          n_chk, n_fail;
  logic [31:0] bank_m [32];

  alu_operand_sequencer dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_op(inst_op),
    .inst_ra(inst_ra), .inst_rb(inst_rb), .inst_rd(inst_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s),
    .alu_r(alu_r), .alu_zflag(alu_zflag),
    .done(done), .err(err), .result(result), .zflag(zflag)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    case (s)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd6:    return x - y;
      4'd7:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd12:   return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit tb_legal(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) ||
           (op == 4'd6) || (op == 4'd7) || (op == 4'd12);
  endfunction

  assign alu_r     = alu_fn(alu_s, alu_x, alu_y);
  assign alu_zflag = (alu_r == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    bank_m[a] = d;
  endtask

  // Issues one instruction from an IDLE cycle and checks it through to IDLE.
  task automatic run_inst(input logic [3:0] op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rd, input bit keep, input bit ld_same, input bit ld_read);
    logic [31:0] exp_r, x_m, y_m;
    bit legal;
    legal = tb_legal(op);
    chk("ready_idle", {31'd0, inst_ready}, 32'd1);
    inst_op = op; inst_ra = ra; inst_rb = rb; inst_rd = rd; inst_valid = 1'b1;
    if (ld_same) begin ld_en = 1'b1; ld_addr = 5'($urandom); ld_data = $urandom; end
    tick();
    ld_en = 1'b0;
    inst_op = 4'($urandom); inst_ra = 5'($urandom); inst_rb = 5'($urandom); inst_rd = 5'($urandom);
    if (!(keep && legal)) inst_valid = 1'b0;
    if (!legal) begin
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_no_done", {31'd0, done}, 32'd0);
      chk("err_ready", {31'd0, inst_ready}, 32'd1);
      tick();
      chk("err_clear", {31'd0, err}, 32'd0);
      return;
    end
    x_m = bank_m[ra];
    y_m = bank_m[rb];
    exp_r = alu_fn(op, x_m, y_m);
    if (ld_read) begin ld_en = 1'b1; ld_addr = 5'($urandom); ld_data = $urandom; end
    chk("read_ready", {31'd0, inst_ready}, 32'd0);
    chk("read_done", {31'd0, done}, 32'd0);
    tick();
    ld_en = 1'b0;
    chk("exec_x", alu_x, x_m);
    chk("exec_y", alu_y, y_m);
    chk("exec_s", {28'd0, alu_s}, {28'd0, op});
    chk("exec_ready", {31'd0, inst_ready}, 32'd0);
    chk("exec_done", {31'd0, done}, 32'd0);
    tick();
    chk("wb_done", {31'd0, done}, 32'd1);
    chk("wb_result", result, exp_r);
    chk("wb_zflag", {31'd0, zflag}, {31'd0, exp_r == 32'd0});
    chk("wb_ready", {31'd0, inst_ready}, 32'd0);
    chk("wb_err", {31'd0, err}, 32'd0);
    bank_m[rd] = exp_r;
    tick();
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_ready", {31'd0, inst_ready}, 32'd1);
    chk("idle_x_hold", alu_x, x_m);
    chk("idle_s_hold", {28'd0, alu_s}, {28'd0, op});
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_x"}, alu_x, 32'd0);
    chk({tag, "_y"}, alu_y, 32'd0);
    chk({tag, "_s"}, {28'd0, alu_s}, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_zflag"}, {31'd0, zflag}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, inst_ready}, 32'd0);
  endtask

  logic [3:0] legal_ops [6];

  initial begin
    logic [3:0] op;
    n_chk = 0; n_fail = 0;
    legal_ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    inst_valid = 1'b0; inst_op = '0; inst_ra = '0; inst_rb = '0; inst_rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_outputs_zero("rst_init");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, inst_ready}, 32'd1);
    tick();

    for (int i = 0; i < 32; i++) do_load(5'(i), $urandom);
    do_load(5'd1, 32'd5);
    do_load(5'd2, 32'd3);
    do_load(5'd7, 32'hdead_beef);

    run_inst(4'd2, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    chk("add_8", result, 32'd8);
    chk("add_z0", {31'd0, zflag}, 32'd0);
    run_inst(4'd6, 5'd1, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0);
    chk("sub_0", result, 32'd0);
    chk("sub_z1", {31'd0, zflag}, 32'd1);
    run_inst(4'd5, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("illegal_result_held", result, 32'd0);

    // Second instruction held valid across the whole first one.
    run_inst(4'd2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    run_inst(4'd0, 5'd3, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("chain_and", result, 32'd0);
    chk("chain_z1", {31'd0, zflag}, 32'd1);
    run_inst(4'd1, 5'd3, 5'd3, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("r3_is_8", result, 32'd8);

    run_inst(4'd2, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of EXEC: the instruction must vanish.
    inst_op = 4'd2; inst_ra = 5'd1; inst_rb = 5'd2; inst_rd = 5'd7; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    reset_outputs_zero("rst_exec");
    tick();
    chk("rst_hold_ready", {31'd0, inst_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", {31'd0, inst_ready}, 32'd1);
    tick();
    chk("rst_no_done", {31'd0, done}, 32'd0);
    run_inst(4'd1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("r7_kept", result, 32'hdead_beef);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) do_load(5'($urandom), $urandom);
      if ($urandom_range(0, 6) == 0) begin
        do op = 4'($urandom); while (tb_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      run_inst(op, 5'($urandom), 5'($urandom), 5'($urandom), 1'b0,
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 32; i++) run_inst(4'd1, 5'(i), 5'(i), 5'(i), 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
